// File: rtl/board_pkg.sv
// Shared board-level constants and the debounce FSM state type for the iCE40 board.
package board_pkg;

    localparam int CLK_HZ = 12000000;

    function automatic int cycles_for_ms(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEBOUNCE_10MS = cycles_for_ms(10);
    localparam int LONG_1S       = cycles_for_ms(1000);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        CHK_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CHK_REL   = 2'd3
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board input pins.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, level + press/release strobes + press counter.
// Optional hold detection (long_press) is built when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int LONG_CYCLES     = LONG_1S
) (
    input  logic       iCE_CLK,
    input  logic       PIO1_02,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    output logic       long_press,
`endif
    output logic [7:0] press_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic             pin_q;
    logic             btn_sync;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    db_state_t        state, state_nxt;
    logic             accept_press, accept_rel;

    sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .clk (iCE_CLK),
        .rst (PIO1_02),
        .d   (btn_raw),
        .q   (pin_q)
    );

    assign btn_sync = ACTIVE_LOW ? ~pin_q : pin_q;
    assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge iCE_CLK or posedge PIO1_02) begin
        if (PIO1_02) state <= RELEASED;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept_press = 1'b0;
        accept_rel   = 1'b0;
        case (state)
            RELEASED:  if (btn_sync) state_nxt = CHK_PRESS;
            CHK_PRESS: begin
                if (!btn_sync) state_nxt = RELEASED;
                else if (cnt_done) begin
                    state_nxt    = PRESSED;
                    accept_press = 1'b1;
                end
            end
            PRESSED:   if (!btn_sync) state_nxt = CHK_REL;
            CHK_REL: begin
                if (btn_sync) state_nxt = PRESSED;
                else if (cnt_done) begin
                    state_nxt  = RELEASED;
                    accept_rel = 1'b1;
                end
            end
            default:   state_nxt = RELEASED;
        endcase
    end

    // Clearing on acceptance keeps the count aligned with the new level, so a
    // reversal right after acceptance still needs a full DEBOUNCE_CYCLES run.
    always_ff @(posedge iCE_CLK or posedge PIO1_02) begin
        if (PIO1_02)                       cnt <= '0;
        else if (accept_press || accept_rel) cnt <= '0;
        else if (btn_sync != btn_level)    cnt <= cnt + 1'b1;
        else                               cnt <= '0;
    end

    always_ff @(posedge iCE_CLK or posedge PIO1_02) begin
        if (PIO1_02) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= accept_press;
            release_pulse <= accept_rel;
            if (accept_press) begin
                btn_level   <= 1'b1;
                press_count <= press_count + 8'd1;
            end else if (accept_rel) begin
                btn_level   <= 1'b0;
            end
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    logic [23:0] hold_cnt;

    always_ff @(posedge iCE_CLK or posedge PIO1_02) begin
        if (PIO1_02)                          hold_cnt <= 24'd0;
        else if (!btn_level)                  hold_cnt <= 24'd0;
        else if (hold_cnt != 24'(LONG_CYCLES)) hold_cnt <= hold_cnt + 24'd1;
    end

    // Gated by btn_level so it drops on the very cycle the level falls.
    assign long_press = btn_level && (hold_cnt == 24'(LONG_CYCLES));
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1).
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b1;
    logic       btn_level, press_pulse, release_pulse;
    logic [7:0] press_count;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    logic       long_press;
`endif

    int checks = 0;
    int errors = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1),
        .LONG_CYCLES     (10)
    ) dut (
        .iCE_CLK       (clk),
        .PIO1_02       (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        .long_press    (long_press),
`endif
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(3);
        checks++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold: level=%b pp=%b rp=%b cnt=%0d, need all 0",
                     btn_level, press_pulse, release_pulse, press_count);
        end
        rst = 1'b0;
        tick(3);
        checks++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle: level=%b pp=%b rp=%b cnt=%0d, need all 0",
                     btn_level, press_pulse, release_pulse, press_count);
        end
    endtask

    task automatic test_clean_press;
        btn_raw = 1'b0;
        tick(5);
        checks++;
        if (btn_level !== 1'b0 || press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL press_early edge5: level=%b pp=%b, need 0 0", btn_level, press_pulse);
        end
        tick(1);
        checks++;
        if (btn_level !== 1'b1 || press_pulse !== 1'b1 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL press_edge6: level=%b pp=%b cnt=%0d, need 1 1 1",
                     btn_level, press_pulse, press_count);
        end
        tick(1);
        checks++;
        if (btn_level !== 1'b1 || press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL press_one_cycle: level=%b pp=%b, need 1 0", btn_level, press_pulse);
        end
        btn_raw = 1'b1;
        tick(5);
        checks++;
        if (btn_level !== 1'b1 || release_pulse !== 1'b0) begin
            errors++;
            $display("FAIL release_early: level=%b rp=%b, need 1 0", btn_level, release_pulse);
        end
        tick(1);
        checks++;
        if (btn_level !== 1'b0 || release_pulse !== 1'b1 || press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL release_edge6: level=%b rp=%b pp=%b, need 0 1 0",
                     btn_level, release_pulse, press_pulse);
        end
        tick(1);
        checks++;
        if (release_pulse !== 1'b0 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL release_one_cycle: rp=%b cnt=%0d, need 0 1", release_pulse, press_count);
        end
    endtask

    task automatic test_async_reset;
        btn_raw = 1'b0;
        tick(8);
        checks++;
        if (btn_level !== 1'b1 || press_count !== 8'd2) begin
            errors++;
            $display("FAIL pre_reset_press: level=%b cnt=%0d, need 1 2", btn_level, press_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: level=%b pp=%b rp=%b cnt=%0d, need all 0",
                     btn_level, press_pulse, release_pulse, press_count);
        end
        btn_raw = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_bounce;
        int strobes = 0;
        int level_hi = 0;
        logic [7:0] pattern;
        pattern = 8'b1000_1000;  // bit i = raw level for cycle i: 0 0 0 1 0 0 0 1
        for (int i = 0; i < 8; i++) begin
            btn_raw = pattern[i];
            tick(1);
            strobes  += int'(press_pulse) + int'(release_pulse);
            level_hi += int'(btn_level);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            strobes  += int'(press_pulse) + int'(release_pulse);
            level_hi += int'(btn_level);
        end
        checks++;
        if (strobes != 0 || level_hi != 0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL bounce_reject: strobes=%0d level_hi_cycles=%0d cnt=%0d, need 0 0 0",
                     strobes, level_hi, press_count);
        end
    endtask

    task automatic test_wrap;
        int pulses = 0;
        int overlap = 0;
        for (int p = 0; p < 256; p++) begin
            btn_raw = 1'b0;
            for (int i = 0; i < 7; i++) begin
                tick(1);
                pulses  += int'(press_pulse);
                overlap += int'(press_pulse & release_pulse);
            end
            btn_raw = 1'b1;
            for (int i = 0; i < 7; i++) begin
                tick(1);
                pulses  += int'(press_pulse);
                overlap += int'(press_pulse & release_pulse);
            end
            if (p == 254) begin
                checks++;
                if (press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: cnt=%0d, need 255", press_count);
                end
            end
        end
        checks++;
        if (press_count !== 8'd0 || pulses != 256) begin
            errors++;
            $display("FAIL wrap_256: cnt=%0d pulses=%0d, need 0 256", press_count, pulses);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL strobe_overlap: cycles=%0d, need 0", overlap);
        end
    endtask

    task automatic test_reset_mid_press;
        btn_raw = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        checks++;
        if (btn_level !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_press_reset: level=%b cnt=%0d, need 0 0", btn_level, press_count);
        end
        tick(2);
        rst = 1'b0;
        tick(5);
        checks++;
        if (press_pulse !== 1'b0 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: pp=%b level=%b, need 0 0", press_pulse, btn_level);
        end
        tick(1);
        checks++;
        if (press_pulse !== 1'b1 || btn_level !== 1'b1 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_press: pp=%b level=%b cnt=%0d, need 1 1 1",
                     press_pulse, btn_level, press_count);
        end
        btn_raw = 1'b1;
        tick(8);
    endtask

    task automatic test_back_to_back;
        // Release requested on the cycle right after acceptance still needs the full debounce.
        btn_raw = 1'b0;
        tick(6);
        btn_raw = 1'b1;
        tick(5);
        checks++;
        if (btn_level !== 1'b1 || release_pulse !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: level=%b rp=%b, need 1 0", btn_level, release_pulse);
        end
        tick(1);
        checks++;
        if (btn_level !== 1'b0 || release_pulse !== 1'b1 || press_count !== 8'd2) begin
            errors++;
            $display("FAIL b2b_release: level=%b rp=%b cnt=%0d, need 0 1 2",
                     btn_level, release_pulse, press_count);
        end
        tick(4);
    endtask

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    task automatic test_long_press;
        btn_raw = 1'b0;
        tick(6);
        checks++;
        if (btn_level !== 1'b1 || long_press !== 1'b0) begin
            errors++;
            $display("FAIL long_start: level=%b lp=%b, need 1 0", btn_level, long_press);
        end
        tick(9);
        checks++;
        if (long_press !== 1'b0) begin
            errors++;
            $display("FAIL long_early: lp=%b, need 0", long_press);
        end
        tick(1);
        checks++;
        if (long_press !== 1'b1) begin
            errors++;
            $display("FAIL long_rise: lp=%b, need 1", long_press);
        end
        tick(4);
        btn_raw = 1'b1;
        tick(5);
        checks++;
        if (long_press !== 1'b1 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL long_hold: lp=%b level=%b, need 1 1", long_press, btn_level);
        end
        tick(1);
        checks++;
        if (long_press !== 1'b0 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL long_fall: lp=%b level=%b, need 0 0", long_press, btn_level);
        end
        tick(4);
    endtask
`endif

    initial begin
        test_reset;
        test_clean_press;
        test_async_reset;
        test_bounce;
        test_wrap;
        test_reset_mid_press;
        test_back_to_back;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        test_long_press;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
